// File: rtl/guess_round_ctrl_if.sv
// Board-side bundle for the guessing-game round sequencer: buttons, switches, secret in; display and beeper out.
interface guess_round_ctrl_if;
  logic [3:0] digit_in;
  logic       confirm_ones;
  logic       confirm_tens;
  logic [7:0] secret_bcd;
  logic [7:0] range_min;
  logic [7:0] range_max;
  logic [3:0] guesses_left;
  logic [3:0] score;
  logic       beep;
  logic       round_start;

  // Board / stimulus side drives buttons, switches and secret.
  modport master (
    output digit_in, confirm_ones, confirm_tens, secret_bcd,
    input  range_min, range_max, guesses_left, score, beep, round_start
  );

  // Sequencer side.
  modport slave (
    input  digit_in, confirm_ones, confirm_tens, secret_bcd,
    output range_min, range_max, guesses_left, score, beep, round_start
  );
endinterface

// File: rtl/guess_round_ctrl.sv
// Round sequencer for the two-digit guessing game: collects a BCD guess,
// narrows the displayed [min,max] range, tracks guesses left and score.
module guess_round_ctrl #(
  parameter logic [3:0] MAX_GUESSES = 4'd7,
  parameter logic [3:0] WIN_SCORE   = 4'd5
) (
  input  logic              clk,
  input  logic              reset,
  guess_round_ctrl_if.slave bus
);

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned BCD_W   = 8;

  typedef enum logic [2:0] {
    NEW_ROUND = 3'd0,
    WAIT_ONES = 3'd1,
    WAIT_TENS = 3'd2,
    COMPARE   = 3'd3,
    WON       = 3'd4,
    LOST      = 3'd5,
    GAME_OVER = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   secret_q, secret_d;
  logic [BCD_W-1:0]   guess_q, guess_d;
  logic [BCD_W-1:0]   min_q, min_d;
  logic [BCD_W-1:0]   max_q, max_d;
  logic [DIGIT_W-1:0] left_q, left_d;
  logic [DIGIT_W-1:0] score_q, score_d;
  logic               beep_q;
  logic               round_start_q;
  logic               ones_prev_q;
  logic               tens_prev_q;

  logic ones_edge;
  logic tens_edge;
  logic digit_ok;

  // Button rising edges; prev regs come out of reset high so a held button is not an edge.
  assign ones_edge = bus.confirm_ones & ~ones_prev_q;
  assign tens_edge = bus.confirm_tens & ~tens_prev_q;
  assign digit_ok  = (bus.digit_in <= 4'd9);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= NEW_ROUND;
    else       state_q <= state_d;
  end

  // Next-state and datapath update decode.
  always_comb begin
    state_d  = state_q;
    secret_d = secret_q;
    guess_d  = guess_q;
    min_d    = min_q;
    max_d    = max_q;
    left_d   = left_q;
    score_d  = score_q;
    unique case (state_q)
      NEW_ROUND: begin
        secret_d = bus.secret_bcd;
        min_d    = 8'h00;
        max_d    = 8'h99;
        left_d   = MAX_GUESSES;
        state_d  = WAIT_ONES;
      end
      WAIT_ONES: begin
        if (ones_edge && digit_ok) begin
          guess_d[3:0] = bus.digit_in;
          state_d      = WAIT_TENS;
        end
      end
      WAIT_TENS: begin
        // Tens takes priority; a lone ones press corrects the ones digit.
        if (tens_edge && digit_ok) begin
          guess_d[7:4] = bus.digit_in;
          state_d      = COMPARE;
        end else if (ones_edge && digit_ok) begin
          guess_d[3:0] = bus.digit_in;
        end
      end
      COMPARE: begin
        if (guess_q == secret_q) begin
          if (score_q != 4'hF) score_d = score_q + 4'd1;
          state_d = (score_d >= WIN_SCORE) ? GAME_OVER : WON;
        end else begin
          // Bounds only ever tighten.
          if ((guess_q > secret_q) && (guess_q < max_q)) max_d = guess_q;
          if ((guess_q < secret_q) && (guess_q > min_q)) min_d = guess_q;
          if (left_q != 4'd0) left_d = left_q - 4'd1;
          state_d = (left_d == 4'd0) ? LOST : WAIT_ONES;
        end
      end
      WON, LOST: begin
        if (ones_edge) state_d = NEW_ROUND;
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: state_d = NEW_ROUND;
    endcase
  end

  // Datapath, edge-detect and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      secret_q      <= 8'h00;
      guess_q       <= 8'h00;
      min_q         <= 8'h00;
      max_q         <= 8'h99;
      left_q        <= MAX_GUESSES;
      score_q       <= 4'd0;
      beep_q        <= 1'b0;
      round_start_q <= 1'b0;
      ones_prev_q   <= 1'b1;
      tens_prev_q   <= 1'b1;
    end else begin
      secret_q      <= secret_d;
      guess_q       <= guess_d;
      min_q         <= min_d;
      max_q         <= max_d;
      left_q        <= left_d;
      score_q       <= score_d;
      beep_q        <= (state_d == WON) || (state_d == LOST) || (state_d == GAME_OVER);
      round_start_q <= (state_q == NEW_ROUND);
      ones_prev_q   <= bus.confirm_ones;
      tens_prev_q   <= bus.confirm_tens;
    end
  end

  assign bus.range_min    = min_q;
  assign bus.range_max    = max_q;
  assign bus.guesses_left = left_q;
  assign bus.score        = score_q;
  assign bus.beep         = beep_q;
  assign bus.round_start  = round_start_q;

endmodule
